// File: rtl/fcp_pkg.sv
// Shared definitions for the FCP master transmitter: mode encodings, FSM states,
// CRC polynomial and the byte parity helper.
package fcp_pkg;

    typedef enum logic [1:0] {
        FCP_MODE_PING  = 2'd0,
        FCP_MODE_FRAME = 2'd1,
        FCP_MODE_RESET = 2'd2
    } fcp_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_PING,
        ST_RST
    } fcp_state_e;

    localparam logic [7:0] FCP_CRC_POLY = 8'h39;

    // Odd parity: the parity bit makes the total number of ones odd.
    function automatic logic fcp_odd_parity(input logic [7:0] b);
        return ~(^b);
    endfunction

endpackage

// File: rtl/fcp_crc8_ser.sv
// Bit-serial CRC-8 (polynomial FCP_CRC_POLY, MSB first). clr has priority over en.
module fcp_crc8_ser
    import fcp_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [7:0] crc
);

    always_ff @(posedge clk) begin
        if (clr)
            crc <= '0;
        else if (en)
            crc <= {crc[6:0], 1'b0} ^ ({8{crc[7] ^ din}} & FCP_CRC_POLY);
    end

endmodule

// File: rtl/fcp_mst_tx_engine.sv
// FCP master line transmitter: pings, reset pulses and sync/data/parity framed bytes.
// Define FCP_TX_CRC_EN to append a CRC-8 byte after the payload.
module fcp_mst_tx_engine
    import fcp_pkg::*;
#(
    parameter int CLK_PER_UI = 20,
    parameter int PING_UI    = 16,
    parameter int RESET_UI   = 100,
    parameter int MAX_BYTES  = 4,
    localparam int LW        = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tx_start,
    input  logic [1:0]             tx_mode,
    input  logic [LW-1:0]          tx_len,
    input  logic [8*MAX_BYTES-1:0] tx_data,
    output logic                   tx_busy,
    output logic                   tx_done,
    output logic                   tx_err,
    output logic                   tx_line
);

    localparam int Q        = CLK_PER_UI / 4;
    localparam int PING_CYC = PING_UI * CLK_PER_UI;
    localparam int RST_CYC  = RESET_UI * CLK_PER_UI;
    localparam int CW       = $clog2(RST_CYC + 1);
    localparam int BW       = $clog2(MAX_BYTES + 2);
`ifdef FCP_TX_CRC_EN
    localparam int CRC_BYTES = 1;
`else
    localparam int CRC_BYTES = 0;
`endif

    fcp_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      bit_q, bit_d;
    logic [BW-1:0]   byte_q, byte_d;
    logic            line_q, line_d;
    logic            err_q, err_d;
    logic            k4_q, k4_d;
    logic            accept;

    logic [LW-1:0]   len_q;
    logic [7:0]      data_q [MAX_BYTES];

    logic [BW-1:0]   len_ext, nb, byte_nx;
    logic [7:0]      sel_cur, sel_nxt, cur_byte, nxt_byte, crc_byte;
    logic [2:0]      nxt_idx;

    assign len_ext = BW'(len_q);
    assign nb      = len_ext + BW'(CRC_BYTES);
    assign byte_nx = byte_q + 1'b1;
    assign nxt_idx = 3'd6 - bit_q[2:0];

`ifdef FCP_TX_CRC_EN
    // Payload bits are fed as they appear on the line; the CRC byte itself is not.
    fcp_crc8_ser u_crc (
        .clk (clk),
        .clr (accept),
        .en  (state_q == ST_DATA && cnt_q == '0 && bit_q < 4'd8 && byte_q < len_ext),
        .din (line_q),
        .crc (crc_byte)
    );
`else
    assign crc_byte = '0;
`endif

    // Byte currently on the line and the one after it; indices past the payload select the CRC.
    always_comb begin
        sel_cur = '0;
        sel_nxt = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (BW'(i) == byte_q)  sel_cur = data_q[i];
            if (BW'(i) == byte_nx) sel_nxt = data_q[i];
        end
        cur_byte = (byte_q  < len_ext) ? sel_cur : crc_byte;
        nxt_byte = (byte_nx < len_ext) ? sel_nxt : crc_byte;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        byte_d  = byte_q;
        line_d  = line_q;
        err_d   = 1'b0;
        k4_d    = k4_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (tx_start) begin
                    accept = 1'b1;
                    case (tx_mode)
                        FCP_MODE_FRAME: begin
                            if (tx_len == '0 || tx_len > LW'(MAX_BYTES)) begin
                                err_d = 1'b1;
                            end else begin
                                state_d = ST_SYNC;
                                bit_d   = '0;
                                byte_d  = '0;
                                line_d  = 1'b1;
                                // Idle line is 0, so four toggles are needed only when the MSB is 1.
                                k4_d    = tx_data[7];
                            end
                        end
                        FCP_MODE_RESET: begin
                            state_d = ST_RST;
                            line_d  = 1'b1;
                        end
                        default: begin
                            state_d = ST_PING;
                            line_d  = 1'b1;
                        end
                    endcase
                end
            end
            ST_SYNC: begin
                if (cnt_q == CW'(Q - 1)) begin
                    cnt_d = '0;
                    if (bit_q == (k4_q ? 4'd3 : 4'd2)) begin
                        bit_d = '0;
                        if (byte_q < nb) begin
                            state_d = ST_DATA;
                            line_d  = cur_byte[7];
                        end else begin
                            state_d = ST_PING;
                            line_d  = 1'b1;
                        end
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        line_d = ~line_q;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == CW'(CLK_PER_UI - 1)) begin
                    cnt_d = '0;
                    if (bit_q == 4'd8) begin
                        state_d = ST_SYNC;
                        bit_d   = '0;
                        byte_d  = byte_nx;
                        line_d  = ~line_q;
                        k4_d    = line_q != ((byte_nx < nb) ? nxt_byte[7] : 1'b1);
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        line_d = (bit_q == 4'd7) ? fcp_odd_parity(cur_byte) : cur_byte[nxt_idx];
                    end
                end
            end
            ST_PING: begin
                if (cnt_q == CW'(PING_CYC - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    line_d  = 1'b0;
                end
            end
            ST_RST: begin
                if (cnt_q == CW'(RST_CYC - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    line_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                line_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            line_q  <= 1'b0;
            err_q   <= 1'b0;
            k4_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            line_q  <= line_d;
            err_q   <= err_d;
            k4_q    <= k4_d;
        end
    end

    // Request payload is held for the whole transmission; it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            len_q <= tx_len;
            for (int i = 0; i < MAX_BYTES; i++)
                data_q[i] <= tx_data[8*i +: 8];
        end
    end

    assign tx_line = line_q;
    assign tx_err  = err_q;
    assign tx_busy = (state_q != ST_IDLE);
    assign tx_done = (state_q == ST_PING && cnt_q == CW'(PING_CYC - 1)) ||
                     (state_q == ST_RST  && cnt_q == CW'(RST_CYC - 1));

endmodule

// File: tb/tb_fcp_mst_tx_engine.sv
// Self-checking bench for fcp_mst_tx_engine: expected line waveforms are built from the
// framing rules (sync toggles, MSB-first bits, odd parity, ping) and compared cycle by cycle.
module tb_fcp_mst_tx_engine;

    localparam int CPU = 20;
    localparam int PUI = 16;
    localparam int RUI = 100;
    localparam int MB  = 4;
    localparam int LW  = $clog2(MB + 1);
    localparam int QC  = CPU / 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            tx_start;
    logic [1:0]      tx_mode;
    logic [LW-1:0]   tx_len;
    logic [8*MB-1:0] tx_data;
    logic            tx_busy, tx_done, tx_err, tx_line;

    int errors = 0;
    int checks = 0;

    bit         exp_q[$];
    logic [7:0] pay_q[$];
    bit         cur_lvl;

    always #5 clk = ~clk;

    fcp_mst_tx_engine #(
        .CLK_PER_UI (CPU),
        .PING_UI    (PUI),
        .RESET_UI   (RUI),
        .MAX_BYTES  (MB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start),
        .tx_mode  (tx_mode),
        .tx_len   (tx_len),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx_err   (tx_err),
        .tx_line  (tx_line)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] crc8_ref();
        logic [7:0] c = 8'h00;
        foreach (pay_q[i]) begin
            c = c ^ pay_q[i];
            for (int b = 0; b < 8; b++)
                c = c[7] ? ((c << 1) ^ 8'h39) : (c << 1);
        end
        return c;
    endfunction

    task automatic push_n(input bit v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic push_sync(input bit nxt);
        int k;
        k = (cur_lvl != nxt) ? 4 : 3;
        for (int i = 0; i < k; i++) begin
            cur_lvl = ~cur_lvl;
            push_n(cur_lvl, QC);
        end
    endtask

    task automatic build_frame();
        logic [7:0] seq[$];
        bit par;
        exp_q.delete();
        cur_lvl = 1'b0;
        seq = pay_q;
`ifdef FCP_TX_CRC_EN
        seq.push_back(crc8_ref());
`endif
        foreach (seq[i]) begin
            push_sync(seq[i][7]);
            for (int b = 7; b >= 0; b--) push_n(seq[i][b], CPU);
            par = ~(^seq[i]);
            push_n(par, CPU);
            cur_lvl = par;
        end
        push_sync(1'b1);
        push_n(1'b1, PUI * CPU);
    endtask

    task automatic build_const(input int n);
        exp_q.delete();
        push_n(1'b1, n);
    endtask

    function automatic logic [8*MB-1:0] pack_payload();
        logic [8*MB-1:0] d = '0;
        foreach (pay_q[i]) d[8*i +: 8] = pay_q[i];
        return d;
    endfunction

    // Issue one request and compare the whole transmission against exp_q.
    task automatic run_txn(input logic [1:0] mode, input int len, input int ign_at, input string tag);
        int n, mism, first, done_cnt, done_at, busy_cnt;
        @(negedge clk);
        tx_start = 1'b1;
        tx_mode  = mode;
        tx_len   = LW'(len);
        tx_data  = pack_payload();
        @(posedge clk);
        n = exp_q.size();
        mism = 0; first = -1; done_cnt = 0; done_at = -1; busy_cnt = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (tx_line !== exp_q[k-1]) begin
                mism++;
                if (first < 0) first = k;
            end
            if (tx_busy === 1'b1) busy_cnt++;
            if (tx_done === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            tx_start = (k == ign_at);
            if (k == ign_at) tx_mode = 2'd0;
        end
        @(negedge clk);
        tx_start = 1'b0;
        check({tag, "_wave_mismatches"}, mism, 0);
        if (mism != 0) check({tag, "_first_bad_cycle"}, first, -1);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_cycle"}, done_at, n);
        check({tag, "_busy_cycles"}, busy_cnt, n);
        check({tag, "_line_after"}, int'(tx_line), 0);
        check({tag, "_busy_after"}, int'(tx_busy), 0);
    endtask

    task automatic run_err(input int len, input string tag);
        int act;
        @(negedge clk);
        tx_start = 1'b1;
        tx_mode  = 2'd1;
        tx_len   = LW'(len);
        tx_data  = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        tx_start = 1'b0;
        check({tag, "_err_pulse"}, int'(tx_err), 1);
        check({tag, "_busy"}, int'(tx_busy), 0);
        act = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            act += int'(tx_line) + int'(tx_done) + int'(tx_busy) + int'(tx_err);
        end
        check({tag, "_quiet_after"}, act, 0);
    endtask

    initial begin
        int len, done_seen;
        rst      = 1'b1;
        tx_start = 1'b0;
        tx_mode  = 2'd0;
        tx_len   = '0;
        tx_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_line", int'(tx_line), 0);
        check("rst_busy", int'(tx_busy), 0);
        check("rst_done", int'(tx_done), 0);
        check("rst_err",  int'(tx_err),  0);
        rst = 1'b0;

        pay_q.delete();
        build_const(PUI * CPU);
        run_txn(2'd0, 0, 0, "ping");

        pay_q.delete();
        pay_q.push_back(8'hA5);
        build_frame();
        run_txn(2'd1, 1, 0, "frame_a5");

        pay_q.delete();
        build_const(RUI * CPU);
        run_txn(2'd2, 0, 500, "reset_pulse");

        run_err(0, "err_len0");
        run_err(5, "err_len5");

        // Reset in the middle of a 4-byte frame.
        pay_q.delete();
        for (int i = 0; i < MB; i++) pay_q.push_back(8'($urandom));
        @(negedge clk);
        tx_start = 1'b1;
        tx_mode  = 2'd1;
        tx_len   = LW'(MB);
        tx_data  = pack_payload();
        @(posedge clk);
        done_seen = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            tx_start = 1'b0;
            done_seen += int'(tx_done);
        end
        check("midrst_busy_before", int'(tx_busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_line", int'(tx_line), 0);
        check("midrst_busy", int'(tx_busy), 0);
        check("midrst_done", done_seen + int'(tx_done), 0);
        pay_q.delete();
        build_const(PUI * CPU);
        run_txn(2'd3, 0, 0, "ping_after_rst");

        for (int t = 0; t < 6; t++) begin
            pay_q.delete();
            len = $urandom_range(1, MB);
            for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
            build_frame();
            run_txn(2'd1, len, 0, $sformatf("rand_frame%0d", t));
        end

        pay_q.delete();
        build_const(PUI * CPU);
        run_txn(($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3, 0, 0, "rand_ping");

`ifdef FCP_TX_CRC_EN
        pay_q.delete();
        pay_q.push_back(8'h12);
        pay_q.push_back(8'h34);
        build_frame();
        run_txn(2'd1, 2, 0, "crc_frame");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fcp_mst_tx_engine.md
Name: fcp_mst_tx_engine

Overview:
- Parametrised master-side transmitter for the single-wire FCP link.
- Serialises a frame of up to MAX_BYTES bytes, optionally followed by a CRC byte, onto one line; each byte is preceded by a quarter-UI sync field and followed by a terminating ping.
- Also issues standalone pings and line-reset pulses.
- Sits between the protocol master FSM (issues start/mode/data) and the line driver.

Parameters:
- CLK_PER_UI, 20, clock cycles per UI; must be a multiple of 4, minimum 8.
- PING_UI, 16, ping length in UI.
- RESET_UI, 100, reset-pulse length in UI.
- MAX_BYTES, 4, maximum payload bytes per frame.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- tx_start  in  1  request pulse; accepted only when tx_busy=0
- tx_mode  in  2  0 ping, 1 frame, 2 reset pulse, 3 treated as ping
- tx_len  in  $clog2(MAX_BYTES+1)  payload byte count (frame mode only)
- tx_data  in  8*MAX_BYTES  payload; byte i at [8i+7:8i], byte 0 sent first
- tx_busy  out  1  transmission in progress
- tx_done  out  1  one-cycle pulse on the last cycle of a transmission
- tx_err  out  1  one-cycle pulse: frame request rejected
- tx_line  out  1  registered line output

Behaviour:
- Reset values: tx_line=0, tx_busy=0, tx_done=0, tx_err=0, FSM=IDLE, all counters 0.
- rst asserted mid-transmission: next edge forces the reset values; no tx_done is issued.
- Accept cycle (tx_start & !tx_busy):
  - tx_mode, tx_len and tx_data are latched.
  - tx_busy=1 from the next cycle.
  - The first tx_line change occurs in the cycle after accept.
  - tx_start while busy is ignored.
- Frame rejection: frame mode with tx_len==0 or tx_len>MAX_BYTES → tx_err pulses the cycle after accept, no line activity, tx_busy stays 0, no tx_done.
- FSM states: IDLE, SYNC, DATA, PING, RST.
  - Ping mode (0 or 3): IDLE→PING.
  - Reset mode: IDLE→RST.
  - Frame mode: IDLE→SYNC→DATA→(SYNC→DATA per byte)→SYNC→PING→IDLE.
- SYNC:
  - K quarter-UI segments, each CLK_PER_UI/4 cycles; tx_line toggles at the start of each segment.
  - K=3 or 4: K is chosen so that the line level at the end of SYNC differs from the next bit.
  - The next bit is the MSB of the next byte, or 1 before the terminating PING.
- DATA:
  - 9 UIs: bits 7..0 MSB first, then an odd-parity bit (parity = ~^byte).
  - tx_line is held at the bit value for the full UI.
- PING: tx_line=1 for PING_UI*CLK_PER_UI cycles, then 0.
- RST: tx_line=1 for RESET_UI*CLK_PER_UI cycles, then 0.
- tx_done pulses in the last cycle of PING or RST. tx_busy falls in the same cycle tx_line returns to 0.
- Counters:
  - Cycle counter width $clog2(RESET_UI*CLK_PER_UI+1); it wraps to 0 at each segment/UI end.
  - A bit counter runs 0..8 within DATA.
  - A byte counter runs 0..tx_len (or tx_len+1 with CRC).

Optional Feature:
- Macro: FCP_TX_CRC_EN.
- Defined:
  - A CRC-8 byte is appended after the last payload byte, with its own SYNC and parity like a data byte.
  - Polynomial 0x39, init 0x00, MSB first, computed over the transmitted payload bytes.
  - The CRC is computed serially during DATA and is ready before the following SYNC.
- Undefined: no CRC byte is sent and the CRC logic is absent. The frame ends with SYNC then PING after the last payload byte.

Decomposition:
- Package fcp_pkg:
  - mode encodings (FCP_MODE_PING/FRAME/RESET);
  - FSM state typedef;
  - FCP_CRC_POLY=8'h39;
  - parity helper function.
- Sub-module fcp_crc8_ser (bitwise serial CRC-8 with clear/enable/bit inputs), instantiated only under FCP_TX_CRC_EN.

Test Plan:
- Ping (defaults): tx_start, mode 0 → tx_line=1 for exactly 320 cycles starting 1 cycle after accept, tx_done on cycle 320, tx_busy 320 cycles.
- Frame, CRC off, len 1, byte 0xA5 → expected tx_line sequence:
  - sync 4 toggles (1,0,1,0, 5 cycles each);
  - bits 1,0,1,0,0,1,0,1 then parity 1, 20 cycles each;
  - end sync 3 toggles (0,1,0);
  - ping high 320 cycles;
  - tx_done at cycle 535 after accept.
- Reset pulse: mode 2 → tx_line high for 2000 cycles, tx_done once, a second tx_start during busy is ignored.
- Errors: mode 1 with tx_len=0, then tx_len=5 → tx_err pulse each time, tx_line stays 0, no tx_done.
- rst asserted at cycle 100 of a 4-byte frame → next cycle tx_line=0, tx_busy=0; a new ping then completes normally.
- With FCP_TX_CRC_EN: len 2, bytes 0x12,0x34 → third byte on the line equals the reference-model CRC-8(0x39) of {0x12,0x34}, with correct parity; total length matches 3 bytes plus ping.
